// File: rtl/param_datapath_if.sv
// Purpose: bundles the decoder-facing control/data bus and the status outputs of param_datapath.
// Latency: none, wires only.
// Backpressure: busy tells the decoder to hold off; anything it presents while busy=1 is dropped.
// Ports: op/A/B/C/D/Y1/Y2/write/const_c/constant/pc_inc/copy_select are driven by the master.
//        copy_out/busy/done/zero_flag/carry_flag are driven by the datapath (slave).
interface param_datapath_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    localparam int AW = $clog2(NREGS);

    logic [2:0]       op;
    logic [AW-1:0]    A;
    logic [AW-1:0]    B;
    logic [AW-1:0]    C;
    logic [AW-1:0]    D;
    logic [AW-1:0]    Y1;
    logic [AW-1:0]    Y2;
    logic [1:0]       write;
    logic             const_c;
    logic [WIDTH-1:0] constant;
    logic             pc_inc;
    logic [AW-1:0]    copy_select;
    logic [WIDTH-1:0] copy_out;
    logic             busy;
    logic             done;
    logic             zero_flag;
    logic             carry_flag;

    modport master (
        output op, A, B, C, D, Y1, Y2, write, const_c, constant, pc_inc, copy_select,
        input  copy_out, busy, done, zero_flag, carry_flag
    );

    modport slave (
        input  op, A, B, C, D, Y1, Y2, write, const_c, constant, pc_inc, copy_select,
        output copy_out, busy, done, zero_flag, carry_flag
    );
endinterface

// File: rtl/param_datapath.sv
// Purpose: NREGS x WIDTH register file with two ALU write lanes, constant injection, PC auto-increment
//          and an iterative shift-add multiplier (one multiplier bit per cycle).
// Latency: single-cycle ops commit on the edge they are presented; multiply commits WIDTH edges after acceptance.
// Backpressure: busy=1 while multiplying; decoder inputs (except pc_inc/copy_select) are ignored then.
// Ports: clk, rst_n (async active-low); dp = slave side of param_datapath_if.
module param_datapath #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 16,
    parameter int PC_REG   = NREGS - 1,
    parameter int PC_STEP  = 4,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    param_datapath_if.slave    dp
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);   // shift-amount field width
    localparam int CW = $clog2(WIDTH);   // multiplier step counter width, covers 0..WIDTH-1

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Single-cycle ALU; bit WIDTH carries the add carry / sub borrow, zero for the other ops.
    function automatic logic [WIDTH:0] alu(input logic [2:0] f,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        case (f)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHL:  r = {1'b0, a << b[SW-1:0]};
            OP_SHR:  r = {1'b0, a >> b[SW-1:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Register 0 is hard-wired to zero on the read side when ZERO_REG is set.
    function automatic logic [WIDTH-1:0] zmask(input logic [AW-1:0] addr,
                                               input logic [WIDTH-1:0] val);
        return (ZERO_REG != 0 && addr == '0) ? '0 : val;
    endfunction

    // State
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      my1_q, my1_d;
    logic [AW-1:0]      my2_q, my2_d;
    logic [1:0]         mwr_q, mwr_d;
    logic               zf_q, zf_d;
    logic               cf_q, cf_d;

    // Operand reads
    logic [WIDTH-1:0] ra, rb, rc, rd;
    assign ra = zmask(dp.A, regs_q[dp.A]);
    assign rb = zmask(dp.B, regs_q[dp.B]);
    assign rc = zmask(dp.C, regs_q[dp.C]);
    assign rd = zmask(dp.D, regs_q[dp.D]);
    assign dp.copy_out = zmask(dp.copy_select, regs_q[dp.copy_select]);

    // Lane results
    logic [WIDTH:0]   alu0, alu1;
    logic [WIDTH-1:0] r0;
    logic             c0;
    assign alu0 = alu(dp.op, ra, rc);
    assign alu1 = alu(dp.op, rb, rd);
    assign r0   = dp.const_c ? dp.constant : alu0[WIDTH-1:0];
    assign c0   = dp.const_c ? 1'b0 : alu0[WIDTH];

    // Op 111 never produces a single-cycle result: it either starts the multiplier
    // (lane 0 only, unless const_c overrides lane 0) or lane 1 simply does not write.
    logic start_mul, lane0_en, lane1_en;
    assign start_mul = (dp.op == OP_MUL) && !dp.const_c && (dp.write != 2'b00);
    assign lane0_en  = dp.write[0] && (dp.const_c || dp.op != OP_MUL);
    assign lane1_en  = dp.write[1] && (dp.op != OP_MUL);

    // One shift-add step: add the multiplicand into the upper half when the current
    // multiplier bit (LSB of prod) is set, then shift the whole product right.
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] p_step;
    assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign p_step   = {step_sum, prod_q[WIDTH-1:1]};

    // Effective write ports for this cycle (either decoder lanes or the multiply commit)
    logic             wr0, wr1;
    logic [AW-1:0]    a0, a1;
    logic [WIDTH-1:0] d0, d1;
    logic             cy0;

    // FSM next-state and write-port selection
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        my1_d   = my1_q;
        my2_d   = my2_q;
        mwr_d   = mwr_q;
        wr0     = 1'b0;
        wr1     = 1'b0;
        a0      = dp.Y1;
        a1      = dp.Y2;
        d0      = r0;
        d1      = alu1[WIDTH-1:0];
        cy0     = c0;

        case (state_q)
            // COMMIT only exists to raise done; the datapath already accepts new ops in it.
            S_IDLE, S_COMMIT: begin
                state_d = S_IDLE;
                if (start_mul) begin
                    state_d = S_MUL;
                    mcand_d = ra;
                    prod_d  = {{WIDTH{1'b0}}, rc};
                    cnt_d   = '0;
                    my1_d   = dp.Y1;
                    my2_d   = dp.Y2;
                    mwr_d   = dp.write;
                end else begin
                    wr0 = lane0_en;
                    wr1 = lane1_en;
                end
            end
            S_MUL: begin
                prod_d = p_step;
                cnt_d  = cnt_q + CW'(1);
                // Last multiplier bit: the product is complete this edge, write it straight away.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_COMMIT;
                    wr0     = mwr_q[0];
                    wr1     = mwr_q[1];
                    a0      = my1_q;
                    a1      = my2_q;
                    d0      = p_step[WIDTH-1:0];
                    d1      = p_step[2*WIDTH-1:WIDTH];
                    cy0     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register-file next state: later assignments win, giving lane 1 > lane 0 > pc_inc.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (dp.pc_inc && i == PC_REG) begin
                regs_d[i] = regs_q[i] + WIDTH'(PC_STEP);
            end
            if (wr0 && a0 == AW'(i)) begin
                regs_d[i] = d0;
            end
            if (wr1 && a1 == AW'(i)) begin
                regs_d[i] = d1;
            end
            if (ZERO_REG != 0 && i == 0) begin
                regs_d[i] = '0;
            end
        end
    end

    // Flags track the lane-0 result whenever lane 0 writes.
    always_comb begin
        zf_d = zf_q;
        cf_d = cf_q;
        if (wr0) begin
            zf_d = (d0 == '0);
            cf_d = cy0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= S_IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            my1_q   <= '0;
            my2_q   <= '0;
            mwr_q   <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            my1_q   <= my1_d;
            my2_q   <= my2_d;
            mwr_q   <= mwr_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
        end
    end

    assign dp.busy       = (state_q == S_MUL);
    assign dp.done       = (state_q == S_COMMIT);
    assign dp.zero_flag  = zf_q;
    assign dp.carry_flag = cf_q;

endmodule

// File: doc/param_datapath.md
# param_datapath

Parametrised successor to the fixed 16×32 datapath: a register file of NREGS×WIDTH words with two write lanes, constant injection, a PC register with auto-increment, and a new iterative multi-cycle multiplier with a busy/done handshake. It sits between the instruction decoder (which drives op, addresses and write enables) and the register-level debug/copy logic. All single-cycle operations commit on the clock edge at which they are presented; multiply stalls the datapath.

## Interface
- WIDTH, 32, data word width (≥4)
- NREGS, 16, number of registers (power of two, ≥4); AW = clog2(NREGS)
- PC_REG, NREGS-1, index of the program-counter register
- PC_STEP, 4, increment applied to PC_REG when pc_inc=1
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes
---
- clk  in  1  clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- op  in  3  operation select (see Operation)
- A, C  in  AW  lane-0 source addresses
- B, D  in  AW  lane-1 source addresses
- Y1, Y2  in  AW  lane-0 / lane-1 destination addresses
- write  in  2  write[0] enables Y1 write, write[1] enables Y2 write
- const_c  in  1  lane-0 result replaced by constant
- constant  in  WIDTH  immediate value for lane 0
- pc_inc  in  1  add PC_STEP to PC_REG this cycle
- copy_select  in  AW  debug read address
- copy_out  out  WIDTH  combinational registers[copy_select]
- busy  out  1  multiplier running; inputs other than pc_inc/copy_select ignored
- done  out  1  one-cycle pulse on multiplier commit
- zero_flag  out  1  registered: last committed lane-0 result == 0
- carry_flag  out  1  registered: carry/borrow of last committed lane-0 add/sub

## Operation
- Reads combinational: rA=reg[A] etc.; reg[0] reads 0 when ZERO_REG=1.
- Lane 0: r0 = rA op rC; lane 1: r1 = rB op rD. Ops: 000 add, 001 sub (borrow → carry_flag=1), 010 and, 011 or, 100 xor, 101 shl by rC/rD[clog2(WIDTH)-1:0], 110 shr logical same amount, 111 multiply.
- const_c=1: r0 = constant regardless of op (op 111 not started); carry_flag cleared.
- Arithmetic modulo 2^WIDTH; carry is bit WIDTH of the unsigned add/sub.
- Flags update only on a cycle where write[0]=1 and a lane-0 result commits.
- Multiply (op=111, const_c=0, write≠0, busy=0): latch rA, rC, Y1, Y2, write; unsigned shift-add, one multiplier bit per cycle. Product 2·WIDTH bits: low half → Y1 (if write[0]), high half → Y2 (if write[1]). Lane 1 sources unused.
- Write priority per register, highest first: lane 1, lane 0, pc_inc. Y1==Y2 with both enabled → lane-1 value stored.
- pc_inc=1 and no explicit write to PC_REG: PC_REG += PC_STEP (wraps). Applies while busy too.
- Writes to reg 0 dropped when ZERO_REG=1.
- States: IDLE → (multiply start) MUL → (count==WIDTH-1) COMMIT → IDLE.

## Timing
- Reset (async, any time incl. mid-multiply): all registers 0, state IDLE, busy=0, done=0, zero_flag=0, carry_flag=0; multiply aborted, nothing written.
- Single-cycle ops: inputs sampled at edge N, register visible via copy_out after edge N. Latency 1.
- Multiply accepted at edge N: busy=1 from after edge N through edge N+WIDTH; result written and done=1 after edge N+WIDTH; busy=0 in that same cycle; new op accepted at edge N+WIDTH+1.
- During busy, op/addresses/write/const_c ignored; ops presented then are lost (decoder must hold off).
- copy_out has no clock latency; reflects registers after each edge.

## Test plan
- Reset, then Y1=1,write=01,const_c=1,constant=5; then Y1=2,constant=7 → R1=5, R2=7, zero_flag=0.
- A=1,C=2,Y1=3,op=000,const_c=0,write=00 for 5 cycles → R3 unchanged (0); write=01 one edge → R3=12, carry_flag=0; op=001 A=1,C=2 → R3=0xFFFFFFFE, carry_flag=1.
- R4=0xFFFFFFFF, R2=7 via constants; op=111,A=4,C=2,Y1=5,Y2=6,write=11 → busy high exactly 32 cycles, done pulse, R5=0xFFFFFFF9, R6=6.
- Y1=Y2=7, write=11, const_c=1 constant=9, op=000 A=B=D=2 (R2=7) → R7=14 (lane 1 wins); explicit write to PC_REG with pc_inc=1 → written value, not incremented.
- pc_inc=1 for 3 cycles from R15=0 → 12; also during a multiply → PC advances while busy; write to R0 → copy_out at 0 reads 0.
- Start multiply, assert rst_n=0 at cycle 10 → busy=0 immediately, all registers 0, done never pulses.
